// File: rtl/conv33_pkg.sv
// Shared types and default dimensions for the conv33 sliding-window datapath.
package conv33_pkg;

  localparam int DATA_WIDTH         = 8;
  localparam int IMG_WIDTH_DEFAULT  = 28;
  localparam int IMG_HEIGHT_DEFAULT = 28;

  typedef logic signed [DATA_WIDTH-1:0] pix_t;

endpackage

// File: rtl/conv33_line_buf.sv
// One image row of pixel storage: combinational read and synchronous write at a shared address.
module conv33_line_buf
  import conv33_pkg::*;
#(
  parameter int DEPTH      = IMG_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = conv33_pkg::DATA_WIDTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic [AW-1:0]                addr,
  input  logic                         we,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  output logic signed [DATA_WIDTH-1:0] rdata
);

  // No reset: stale contents are never flagged valid before being rewritten.
  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/conv33_window.sv
// Raster-stream 3x3 window generator feeding conv33_calc (valid convolution, no padding).
// Build option CONV33_WIN_STRIDE2_EN: flag only every second window in each direction.
module conv33_window
  import conv33_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT,
  parameter int DATA_WIDTH = conv33_pkg::DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [DATA_WIDTH-1:0]    pix_in,
  input  logic                            pix_valid,
  input  logic                            pix_sof,
  output logic signed [DATA_WIDTH-1:0]    data_0_0,
  output logic signed [DATA_WIDTH-1:0]    data_0_1,
  output logic signed [DATA_WIDTH-1:0]    data_0_2,
  output logic signed [DATA_WIDTH-1:0]    data_1_0,
  output logic signed [DATA_WIDTH-1:0]    data_1_1,
  output logic signed [DATA_WIDTH-1:0]    data_1_2,
  output logic signed [DATA_WIDTH-1:0]    data_2_0,
  output logic signed [DATA_WIDTH-1:0]    data_2_1,
  output logic signed [DATA_WIDTH-1:0]    data_2_2,
  output logic                            conv33_en,
  output logic [$clog2(IMG_HEIGHT)-1:0]   win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]    win_col,
  output logic                            frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

`ifdef CONV33_WIN_STRIDE2_EN
  localparam bit STRIDE2 = 1'b1;
`else
  localparam bit STRIDE2 = 1'b0;
`endif

  // Input position of the pixel that completes the final flagged window.
  localparam int LAST_COL = STRIDE2 ? 2 + 2 * ((IMG_WIDTH - 3) / 2)  : IMG_WIDTH - 1;
  localparam int LAST_ROW = STRIDE2 ? 2 + 2 * ((IMG_HEIGHT - 3) / 2) : IMG_HEIGHT - 1;

  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [CW-1:0] COL_LAST = CW'(LAST_COL);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(LAST_ROW);

  logic [CW-1:0] col_q, col_d, cur_col, col_off;
  logic [RW-1:0] row_q, row_d, cur_row, row_off;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic          en_q, en_d;
  logic          fd_q, fd_d;
  logic          sof_hit;
  logic          hit;

  logic signed [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
  logic signed [DATA_WIDTH-1:0] win_q [3][3];

  always_comb begin
    sof_hit   = pix_valid & pix_sof;
    cur_col   = sof_hit ? '0 : col_q;
    cur_row   = sof_hit ? '0 : row_q;
    col_d     = col_q;
    row_d     = row_q;
    win_col_d = win_col_q;
    win_row_d = win_row_q;

    if (pix_valid) begin
      if (cur_col == COL_MAX) begin
        col_d = '0;
        row_d = (cur_row == ROW_MAX) ? '0 : cur_row + ROW_ONE;
      end else begin
        col_d = cur_col + COL_ONE;
        row_d = cur_row;
      end
    end

    col_off = cur_col - COL_TWO;
    row_off = cur_row - ROW_TWO;
    hit     = (cur_col >= COL_TWO) && (cur_row >= ROW_TWO);
    if (STRIDE2) hit = hit & ~col_off[0] & ~row_off[0];

    en_d = pix_valid & hit;
    fd_d = en_d && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    if (en_d) begin
      win_col_d = STRIDE2 ? (col_off >> 1) : col_off;
      win_row_d = STRIDE2 ? (row_off >> 1) : row_off;
    end
  end

  // line0 holds row-2, line1 holds row-1; the oldest row shifts up as the new pixel lands.
  conv33_line_buf #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_line0 (
    .clk   (clk),
    .addr  (cur_col),
    .we    (pix_valid),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  conv33_line_buf #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_line1 (
    .clk   (clk),
    .addr  (cur_col),
    .we    (pix_valid),
    .wdata (pix_in),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      win_col_q <= '0;
      win_row_q <= '0;
      en_q      <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      win_col_q <= win_col_d;
      win_row_q <= win_row_d;
      en_q      <= en_d;
      fd_q      <= fd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      end
    end else if (pix_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb0_rd;
      win_q[1][2] <= lb1_rd;
      win_q[2][2] <= pix_in;
    end
  end

  assign data_0_0   = win_q[0][0];
  assign data_0_1   = win_q[0][1];
  assign data_0_2   = win_q[0][2];
  assign data_1_0   = win_q[1][0];
  assign data_1_1   = win_q[1][1];
  assign data_1_2   = win_q[1][2];
  assign data_2_0   = win_q[2][0];
  assign data_2_1   = win_q[2][1];
  assign data_2_2   = win_q[2][2];
  assign conv33_en  = en_q;
  assign frame_done = fd_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule

// File: tb/tb_conv33_window.sv
// Directed bench for conv33_window on a small image (4x4, or 5x5 with CONV33_WIN_STRIDE2_EN).
module tb_conv33_window;

`ifdef CONV33_WIN_STRIDE2_EN
  localparam int W = 5;
  localparam int H = 5;
  localparam int S = 2;
`else
  localparam int W = 4;
  localparam int H = 4;
  localparam int S = 1;
`endif
  localparam int NC   = (W - 3) / S + 1;
  localparam int NR   = (H - 3) / S + 1;
  localparam int NWIN = NC * NR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [7:0] pix_in = '0;
  logic pix_valid = 1'b0;
  logic pix_sof   = 1'b0;
  logic signed [7:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
  logic conv33_en, frame_done;
  logic [$clog2(H)-1:0] win_row;
  logic [$clog2(W)-1:0] win_col;

  conv33_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .data_0_0   (d00),
    .data_0_1   (d01),
    .data_0_2   (d02),
    .data_1_0   (d10),
    .data_1_1   (d11),
    .data_1_2   (d12),
    .data_2_0   (d20),
    .data_2_1   (d21),
    .data_2_2   (d22),
    .conv33_en  (conv33_en),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] taps;
    logic [7:0]  r;
    logic [7:0]  c;
    logic        fd;
  } rec_t;

  rec_t recs[$];
  rec_t mon_rec;
  int   fd_total  = 0;
  int   gap_viol  = 0;
  logic last_valid = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [71:0] taps_now();
    return {d00, d01, d02, d10, d11, d12, d20, d21, d22};
  endfunction

  function automatic logic [71:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a4), 8'(a5), 8'(a6), 8'(a7), 8'(a8)};
  endfunction

  // Pixel value at (r,c) is base + r*W + c; output window (wr,wc) starts at (S*wr, S*wc).
  function automatic logic [71:0] exp_win(input int base, input int wr, input int wc);
    logic [71:0] res = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        res = {res[63:0], 8'(base + (S * wr + i) * W + S * wc + j)};
    return res;
  endfunction

  always @(negedge clk) begin
    if (conv33_en) begin
      mon_rec.taps = taps_now();
      mon_rec.r    = 8'(win_row);
      mon_rec.c    = 8'(win_col);
      mon_rec.fd   = frame_done;
      recs.push_back(mon_rec);
      if (!last_valid) gap_viol++;
    end
    if (frame_done) fd_total++;
    last_valid = pix_valid & ~rst;
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int v, input bit sof);
    @(posedge clk);
    #1;
    pix_valid = 1'b1;
    pix_in    = 8'(v);
    pix_sof   = sof;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
    end
  endtask

  task automatic send_frame(input int base, input bit sof, input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      send(base + i, sof && (i == 0));
      if (gaps) idle(1);
    end
  endtask

  task automatic check_frame(input string tag, input int base, input int first);
    for (int wr = 0; wr < NR; wr++) begin
      for (int wc = 0; wc < NC; wc++) begin
        int k;
        k = first + wr * NC + wc;
        if (k < recs.size()) begin
          check({tag, "_taps"}, recs[k].taps, exp_win(base, wr, wc));
          check({tag, "_pos"}, 72'({recs[k].r, recs[k].c}), 72'({8'(wr), 8'(wc)}));
          check({tag, "_fd"}, 72'(recs[k].fd), 72'((wr == NR - 1) && (wc == NC - 1)));
        end else begin
          check({tag, "_missing"}, 72'(recs.size()), 72'(k + 1));
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_taps"}, taps_now(), 72'(0));
    check({tag, "_ctl"}, 72'({conv33_en, frame_done, win_row, win_col}), 72'(0));
  endtask

  task automatic clear_log();
    recs.delete();
    fd_total = 0;
    gap_viol = 0;
  endtask

  initial begin
    idle(2);
    @(negedge clk);
    check_reset_outputs("rst_init");
    @(posedge clk);
    #1 rst = 1'b0;
    clear_log();

`ifdef CONV33_WIN_STRIDE2_EN
    send_frame(1, 1'b1, 1'b0);
    idle(3);
    check("s6_count", 72'(recs.size()), 72'(4));
    check("s6_fd_total", 72'(fd_total), 72'(1));
    check_frame("s6", 1, 0);
    if (recs.size() >= 4) begin
      check("s6_first", recs[0].taps, mk(1, 2, 3, 6, 7, 8, 11, 12, 13));
      check("s6_last", recs[3].taps, mk(13, 14, 15, 18, 19, 20, 23, 24, 25));
      check("s6_last_fd", 72'(recs[3].fd), 72'(1));
    end
`else
    for (int i = 1; i <= 11; i++) send(i, i == 1);
    @(negedge clk);
    check("s1_en_before", 72'(conv33_en), 72'(0));
    send(12, 1'b0);
    @(negedge clk);
    check("s1_en_first", 72'(conv33_en), 72'(1));
    check("s1_first_taps", taps_now(), mk(1, 2, 3, 5, 6, 7, 9, 10, 11));
    for (int i = 13; i <= 16; i++) send(i, 1'b0);
    idle(3);
    check("s1_count", 72'(recs.size()), 72'(4));
    check("s1_fd_total", 72'(fd_total), 72'(1));
    check_frame("s1", 1, 0);
    if (recs.size() >= 4) begin
      check("s1_last_taps", recs[3].taps, mk(6, 7, 8, 10, 11, 12, 14, 15, 16));
      check("s1_last_fd", 72'(recs[3].fd), 72'(1));
    end
`endif

    clear_log();
    send_frame(1, 1'b1, 1'b1);
    idle(3);
    check("s2_count", 72'(recs.size()), 72'(NWIN));
    check("s2_gap_en", 72'(gap_viol), 72'(0));
    check("s2_fd_total", 72'(fd_total), 72'(1));
    check_frame("s2", 1, 0);

    clear_log();
    send_frame(1, 1'b1, 1'b0);
    send_frame(101, 1'b0, 1'b0);
    idle(3);
    check("s3_count", 72'(recs.size()), 72'(2 * NWIN));
    check("s3_fd_total", 72'(fd_total), 72'(2));
    check_frame("s3a", 1, 0);
    check_frame("s3b", 101, NWIN);

    clear_log();
    for (int i = 1; i <= 9; i++) send(i, i == 1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("s4_in_rst");
    idle(2);
    @(negedge clk);
    check_reset_outputs("s4_held");
    @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
    send_frame(1, 1'b0, 1'b0);
    idle(3);
    check("s4_count", 72'(recs.size()), 72'(NWIN));
    check("s4_fd_total", 72'(fd_total), 72'(1));
    check_frame("s4", 1, 0);

    clear_log();
    for (int i = 1; i <= 6; i++) send(i, i == 1);
    send_frame(1, 1'b1, 1'b0);
    idle(3);
    check("s5_count", 72'(recs.size()), 72'(NWIN));
    check("s5_fd_total", 72'(fd_total), 72'(1));
    check_frame("s5", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
